data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the per-thread data memory valid/ready interface driven by a compute core's LSUs.
- Owns a single-port storage array and serialises all NUM_PORTS read and write requests through it under round-robin arbitration.
- Holds each ready high until the requester drops valid.
- Used as the data memory model and endpoint in core-level simulation and small FPGA builds; also provides a preload port for kernel data.

Parameters:
- ADDR_BITS, 8, data memory address width; array depth 2^ADDR_BITS.
- DATA_BITS, 8, data word width.
- NUM_PORTS, 4, number of requester ports (one per thread).
- ACCESS_LATENCY, 1, edges (>=1) between grant and the ready/commit edge.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- read_valid  input  [NUM_PORTS-1:0]  per-port read request
- read_address  input  [ADDR_BITS-1:0] x NUM_PORTS  read address
- read_ready  output  [NUM_PORTS-1:0]  read response valid; held until read_valid drops
- read_data  output  [DATA_BITS-1:0] x NUM_PORTS  read data; valid while read_ready is high
- write_valid  input  [NUM_PORTS-1:0]  per-port write request
- write_address  input  [ADDR_BITS-1:0] x NUM_PORTS  write address
- write_data  input  [DATA_BITS-1:0] x NUM_PORTS  write data
- write_ready  output  [NUM_PORTS-1:0]  write committed; held until write_valid drops
- init_we  input  1  preload write strobe
- init_addr  input  [ADDR_BITS-1:0]  preload address
- init_data  input  [DATA_BITS-1:0]  preload data
- busy  output  1  high in ACCESS or RELAY

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: all read_ready and write_ready are 0, all read_data is 0, busy is 0, FSM is IDLE, RR pointer is 0. Array contents are not cleared.
- Requesters: 2*NUM_PORTS in total. Index i < NUM_PORTS is read port i; index NUM_PORTS+i is write port i.
- FSM states: IDLE, ACCESS, RELAY.
- IDLE:
  - If any requester is valid, grant the first valid index at or after the RR pointer, searching with wrap-around.
  - Latch the granted index, address and write data; load the latency counter with ACCESS_LATENCY-1; go to ACCESS.
  - If nothing is valid, stay in IDLE.
- ACCESS:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, perform the access and go to RELAY:
    - read: read_data[p] gets array[addr]; read_ready[p] gets 1.
    - write: array[addr] gets data; write_ready[p] gets 1.
  - Result: ready rises ACCESS_LATENCY edges after the grant edge.
- RELAY:
  - Ready and read_data are held.
  - On the first edge where the granted valid is sampled low: ready goes to 0, RR pointer becomes (granted index + 1) mod 2*NUM_PORTS, and the FSM returns to IDLE.
  - The earliest next grant is on the following edge.
- Ordering and fairness:
  - At most one ready is high at any time.
  - A requester that holds valid is granted within 2*NUM_PORTS transactions.
- Valid is latched at grant. A requester that drops valid during ACCESS still completes: ready pulses for one cycle, then the FSM returns to IDLE.
- read_data[p] holds its last value after ready drops. Only the granted port's read_data changes.
- Same port with read_valid and write_valid both high: handled by RR order; no special priority.
- Preload port:
  - init_we writes the array on any edge in any state.
  - Same edge and same address as a committing write: init_data wins.
  - Same edge and same address as a committing read: the read returns the old contents.
- Address is used modulo 2^ADDR_BITS; there is no out-of-range error.
- Reset mid-operation: the transaction is aborted, ready drops on that edge, and an ACCESS write that has not yet committed is discarded.

Optional Feature:
- Macro: DATA_MEM_RESPONDER_STATS_EN.
- When defined, three extra outputs are added:
  - read_count [15:0]: increments on each read commit edge.
  - write_count [15:0]: increments on each write commit edge.
  - stall_cycles [15:0]: increments each edge where some valid requester is high but not granted or in service.
- All three counters are cleared by reset and saturate at 16'hFFFF.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Preload array[0x10]=0xA5 via init; port 0 raises read_valid with addr 0x10 -> read_ready[0] rises 1 edge after grant with read_data[0]=0xA5, holds until valid drops, falls the next edge.
2. Port 2 writes 0x3C to 0x20 and completes the handshake; port 1 then reads 0x20 -> write_ready[2] pulse protocol correct; read_data[1]=0x3C.
3. All four read_valid rise on the same edge from reset (pointer 0), each dropping valid one edge after its ready -> grants in order 0,1,2,3; never two readies high at once.
4. ACCESS_LATENCY=3 -> ready rises exactly 3 edges after grant; busy high from the grant edge until the return to IDLE.
5. Write to 0x40 pending in ACCESS, reset asserted for one edge -> all readies 0, array[0x40] unchanged, FSM in IDLE.
6. Committing write of 0x11 to 0x05 coincides with init_we writing 0x22 to 0x05 -> array[0x05]=0x22. With STATS_EN, write_count=1.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Per-thread data memory valid/ready bundle between core LSUs (master) and
// the data memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]                read_valid;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] read_address;
    logic [NUM_PORTS-1:0]                read_ready;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] read_data;
    logic [NUM_PORTS-1:0]                write_valid;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] write_address;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] write_data;
    logic [NUM_PORTS-1:0]                write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory serving NUM_PORTS read and write requesters round-robin.
// Optional counters enabled by defining DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int NUM_PORTS      = 4,
    parameter int ACCESS_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [DATA_BITS-1:0] init_data,
    output logic                 busy
`ifdef DATA_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count,
    output logic [15:0]          stall_cycles
`endif
);
    localparam int REQS   = 2 * NUM_PORTS;
    localparam int IDX_W  = $clog2(REQS);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam int DEPTH  = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RELAY  = 2'd2
    } state_e;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    state_e                              state_q, state_d;
    logic [IDX_W-1:0]                    grant_q, grant_d;
    logic [IDX_W-1:0]                    rr_q, rr_d;
    logic [ADDR_BITS-1:0]                addr_q, addr_d;
    logic [DATA_BITS-1:0]                wdata_q, wdata_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]                rready_q, rready_d;
    logic [NUM_PORTS-1:0]                wready_q, wready_d;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
    logic                                busy_q;

    logic [REQS-1:0]   req_s;
    logic              found_s;
    logic [IDX_W-1:0]  sel_s;
    logic [PORT_W-1:0] sel_port_s;
    logic [PORT_W-1:0] gnt_port_s;
    logic              gnt_wr_s;
    logic              commit_s;
    logic              commit_wr_s;

    function automatic logic [PORT_W-1:0] port_of(input logic [IDX_W-1:0] idx);
        if (idx >= IDX_W'(NUM_PORTS)) begin
            return PORT_W'(idx - IDX_W'(NUM_PORTS));
        end else begin
            return PORT_W'(idx);
        end
    endfunction

    function automatic logic is_write(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_W'(NUM_PORTS));
    endfunction

    // Reads occupy the low requester indices, writes the high ones.
    assign req_s       = {bus.write_valid, bus.read_valid};
    assign sel_port_s  = port_of(sel_s);
    assign gnt_port_s  = port_of(grant_q);
    assign gnt_wr_s    = is_write(grant_q);
    assign commit_s    = (state_q == ACCESS) && (cnt_q == '0);
    assign commit_wr_s = commit_s && gnt_wr_s && !reset;

    assign bus.read_ready  = rready_q;
    assign bus.write_ready = wready_q;
    assign bus.read_data   = rdata_q;
    assign busy            = busy_q;

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int k = 0; k < REQS; k++) begin
            if (!found_s && req_s[IDX_W'((int'(rr_q) + k) % REQS)]) begin
                found_s = 1'b1;
                sel_s   = IDX_W'((int'(rr_q) + k) % REQS);
            end else begin
                sel_s   = sel_s;
            end
        end
    end

    // Next-state and output decode for the grant/access/relay sequence.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rready_d = rready_q;
        wready_d = wready_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_d = sel_s;
                    addr_d  = is_write(sel_s) ? bus.write_address[sel_port_s]
                                              : bus.read_address[sel_port_s];
                    wdata_d = bus.write_data[sel_port_s];
                    cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RELAY;
                    if (gnt_wr_s) begin
                        wready_d[gnt_port_s] = 1'b1;
                    end else begin
                        rready_d[gnt_port_s] = 1'b1;
                        rdata_d[gnt_port_s]  = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELAY: begin
                if (!req_s[grant_q]) begin
                    rready_d = '0;
                    wready_d = '0;
                    rr_d     = (grant_q == IDX_W'(REQS - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d  = IDLE;
                end else begin
                    state_d  = RELAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rready_q <= '0;
            wready_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rready_q <= rready_d;
            wready_q <= wready_d;
            rdata_q  <= rdata_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Storage array: preload is applied after the commit so it wins on a collision.
    always_ff @(posedge clk) begin
        if (commit_wr_s) begin
            mem_q[addr_q] <= wdata_q;
        end
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [REQS-1:0] mask_s;
    logic            stall_s;
    logic [15:0]     rd_cnt_q, wr_cnt_q, stall_q;

    // Requesters currently granted or in service do not count as stalled.
    always_comb begin
        mask_s = '0;
        if (state_q == IDLE) begin
            if (found_s) begin
                mask_s[sel_s] = 1'b1;
            end else begin
                mask_s = '0;
            end
        end else begin
            mask_s[grant_q] = 1'b1;
        end
        stall_s = |(req_s & ~mask_s);
    end

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
            stall_q  <= 16'h0000;
        end else begin
            if (commit_s && !gnt_wr_s && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'h0001;
            if (commit_s && gnt_wr_s && (wr_cnt_q != 16'hFFFF))  wr_cnt_q <= wr_cnt_q + 16'h0001;
            if (stall_s && (stall_q != 16'hFFFF))                stall_q  <= stall_q + 16'h0001;
        end
    end

    assign read_count   = rd_cnt_q;
    assign write_count  = wr_cnt_q;
    assign stall_cycles = stall_q;
`endif
endmodule
